adder_bist: RTL
===============

ADDER_BIST -- requirements
Module: adder_bist

Interface
REQ-001 Parameter: WIDTH, 16, operand width of the adder under test; legal range 1..16.
REQ-002 Parameter: NUM_VECTORS, 256, number of LFSR vectors per run; legal range 1..65535.
REQ-003 Parameter: SEED, 32'h1234_ACE1, LFSR start value; SHALL be non-zero.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_i  input  1  reset; synchronous, active-high.
REQ-006 start_i  input  1  run request, sampled in IDLE or DONE only.
REQ-007 a_o  output  WIDTH  registered operand A to the adder.
REQ-008 b_o  output  WIDTH  registered operand B to the adder.
REQ-009 sum_i  input  WIDTH  adder sum; one-cycle registered latency relative to a_o/b_o.
REQ-010 carry_i  input  1  adder carry out; combinational, same cycle as a_o/b_o.
REQ-011 busy_o  output  1  high in RUN and DRAIN.
REQ-012 done_o  output  1  high in DONE.
REQ-013 pass_o  output  1  high in DONE when err_count_o == 0.
REQ-014 err_count_o  output  16  mismatch event count, saturating.

Function
REQ-015 FSM states: IDLE, RUN, DRAIN, DONE; rst_i forces IDLE.
REQ-016 IDLE/DONE --start_i--> RUN; on that edge: vector index, err_count_o, LFSR (to SEED) cleared/loaded; vector 0 presented on a_o/b_o.
REQ-017 RUN: one vector per cycle; after the last vector's edge -> DRAIN; DRAIN lasts exactly one cycle -> DONE.
REQ-018 DONE holds done_o, pass_o, err_count_o stable until start_i or rst_i.
REQ-019 start_i in RUN or DRAIN SHALL be ignored.
REQ-020 LFSR: 32-bit Fibonacci, next = {lfsr[30:0], lfsr[31]^lfsr[21]^lfsr[1]^lfsr[0]}, advanced once per RUN vector.
REQ-021 LFSR vector: a_o = lfsr[WIDTH-1:0], b_o = lfsr[WIDTH+15:16].
REQ-022 Expected result = a_o + b_o at WIDTH+1 bits; MSB is expected carry.
REQ-023 Carry check: in every RUN cycle, carry_i compared with expected carry of the vector currently on a_o/b_o.
REQ-024 Sum check: in the cycle after each vector (RUN or DRAIN), sum_i compared with stored expected sum of that vector.
REQ-025 Each mismatch is one event; up to 2 events per cycle (carry of vector k, sum of vector k-1); err_count_o adds them, saturates at 16'hFFFF.
REQ-026 a_o/b_o = 0 in IDLE, DRAIN, DONE; no checks outside RUN/DRAIN.

Reset
REQ-027 On rst_i (any state, including mid-run): state IDLE, a_o=0, b_o=0, busy_o=0, done_o=0, pass_o=0, err_count_o=0, LFSR=SEED, pending sum check discarded.
REQ-028 rst_i has priority over start_i in the same cycle.

Configuration
REQ-029 Macro ADDER_BIST_CORNER_EN defined: RUN first applies 4 corner vectors in order (0,0), (all-ones,1), (all-ones,all-ones), (0x5555..,0xAAAA..) truncated to WIDTH, then NUM_VECTORS LFSR vectors starting from SEED; LFSR does not advance during corners.
REQ-030 Macro undefined: no corner vectors; RUN lasts exactly NUM_VECTORS cycles; no corner logic present.

Verification
REQ-031 Reset: assert rst_i 2 cycles -> all outputs 0, busy_o=0, done_o=0.
REQ-032 WIDTH=16, NUM_VECTORS=4, no macro, ideal adder model: start_i pulse -> vector 0 a_o=16'hACE1, b_o=16'h1234 (expected sum 16'hBF15, carry 0); busy_o 5 cycles; done_o=1, pass_o=1, err_count_o=0.
REQ-033 Same config, sum_i bit 0 inverted -> done_o=1, err_count_o=4, pass_o=0.
REQ-034 ADDER_BIST_CORNER_EN, NUM_VECTORS=4, carry_i tied 0 -> first two busy-cycle a_o values 16'h0000, 16'hFFFF; err_count_o >= 2 (vectors 1 and 2).
REQ-035 rst_i asserted during RUN vector 2 -> next cycle IDLE, all outputs 0; new start_i runs full sequence from vector 0 with err_count_o from 0.
REQ-036 err_count_o saturation: NUM_VECTORS=65535, sum_i and carry_i forced wrong -> err_count_o stops at 16'hFFFF, no wrap.

Source files
------------

// File: rtl/adder_bist.sv
// adder_bist: LFSR-driven built-in self test for a WIDTH-bit adder.
// Define ADDER_BIST_CORNER_EN to prepend four fixed corner vectors to a run.
module adder_bist #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned NUM_VECTORS = 256,
  parameter logic [31:0] SEED        = 32'h1234_ACE1
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             start_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  input  logic [WIDTH-1:0] sum_i,
  input  logic             carry_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [15:0]      err_count_o
);

`ifdef ADDER_BIST_CORNER_EN
  localparam int unsigned NCORNER = 4;
`else
  localparam int unsigned NCORNER = 0;
`endif
  localparam logic [16:0] LAST = 17'(NUM_VECTORS + NCORNER - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [31:0]      lfsr_q;
  logic [16:0]      idx_q;
  logic [WIDTH-1:0] exp_sum_q;
  logic             sum_pend_q;
  logic [15:0]      err_q;

  logic             last_vec;
  logic [16:0]      idx_nx;
  logic [31:0]      lfsr_nx;
  logic [WIDTH-1:0] nxt_a;
  logic [WIDTH-1:0] nxt_b;
  logic [WIDTH:0]   exp_full;
  logic             carry_err;
  logic             sum_err;
  logic [1:0]       inc;
  logic [16:0]      err_sum;
  logic [15:0]      err_add;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

`ifdef ADDER_BIST_CORNER_EN
  // Returns {b, a} for corner vector k.
  function automatic logic [2*WIDTH-1:0] corner_vec(input logic [1:0] k);
    logic [15:0] h5;
    logic [15:0] ha;
    h5 = 16'h5555;
    ha = 16'hAAAA;
    unique case (k)
      2'd0:    return {{WIDTH{1'b0}}, {WIDTH{1'b0}}};
      2'd1:    return {WIDTH'(1), {WIDTH{1'b1}}};
      2'd2:    return {{WIDTH{1'b1}}, {WIDTH{1'b1}}};
      default: return {ha[WIDTH-1:0], h5[WIDTH-1:0]};
    endcase
  endfunction
`endif

  assign last_vec    = (idx_q == LAST);
  assign err_count_o = err_q;
  assign pass_o      = done_o && (err_q == 16'd0);

  // State register.
  always_ff @(posedge clk) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and status decode.
  always_comb begin
    state_d = state_q;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) state_d = RUN;
      end
      RUN: begin
        busy_o = 1'b1;
        if (last_vec) state_d = DRAIN;
      end
      DRAIN: begin
        busy_o  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done_o = 1'b1;
        if (start_i) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Vector to present after the current one.
  always_comb begin
    idx_nx  = idx_q + 17'd1;
    lfsr_nx = lfsr_step(lfsr_q);
    nxt_a   = lfsr_nx[WIDTH-1:0];
    nxt_b   = lfsr_nx[WIDTH+15:16];
`ifdef ADDER_BIST_CORNER_EN
    if (idx_nx < 17'd4) begin
      lfsr_nx        = lfsr_q;
      {nxt_b, nxt_a} = corner_vec(idx_nx[1:0]);
    end else if (idx_nx == 17'd4) begin
      lfsr_nx = lfsr_q;
      nxt_a   = lfsr_q[WIDTH-1:0];
      nxt_b   = lfsr_q[WIDTH+15:16];
    end
`endif
  end

  // Carry and sum checks with a saturating event count.
  always_comb begin
    exp_full  = {1'b0, a_o} + {1'b0, b_o};
    carry_err = (state_q == RUN) && (carry_i != exp_full[WIDTH]);
    sum_err   = busy_o && sum_pend_q && (sum_i != exp_sum_q);
    inc       = {1'b0, carry_err} + {1'b0, sum_err};
    err_sum   = {1'b0, err_q} + {15'd0, inc};
    err_add   = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  // Vector sequencing, expected-sum pipeline and error count.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      lfsr_q     <= SEED;
      idx_q      <= 17'd0;
      a_o        <= '0;
      b_o        <= '0;
      exp_sum_q  <= '0;
      sum_pend_q <= 1'b0;
      err_q      <= 16'd0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            lfsr_q     <= SEED;
            idx_q      <= 17'd0;
            sum_pend_q <= 1'b0;
            err_q      <= 16'd0;
`ifdef ADDER_BIST_CORNER_EN
            a_o        <= '0;
            b_o        <= '0;
`else
            a_o        <= SEED[WIDTH-1:0];
            b_o        <= SEED[WIDTH+15:16];
`endif
          end
        end
        RUN: begin
          err_q      <= err_add;
          exp_sum_q  <= exp_full[WIDTH-1:0];
          sum_pend_q <= 1'b1;
          if (last_vec) begin
            a_o <= '0;
            b_o <= '0;
          end else begin
            idx_q  <= idx_nx;
            lfsr_q <= lfsr_nx;
            a_o    <= nxt_a;
            b_o    <= nxt_b;
          end
        end
        DRAIN: begin
          err_q      <= err_add;
          sum_pend_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
